// File: rtl/matrix_pkg.sv
// Shared types and defaults for the scrolling LED matrix scanner.
package matrix_pkg;

  typedef enum logic {
    ST_ON    = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  localparam int ROWS          = 7;
  localparam int COLS_DEF      = 8;
  localparam int SCAN_DIV_DEF  = 16;
  localparam int BLANK_CYC_DEF = 1;

endpackage

// File: rtl/column_window.sv
// Display window: COLS columns of ROWS bits, scrolls left with new data entering at the right.
module column_window #(
  parameter int COLS = 8,
  parameter int ROWS = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 shift,
  input  logic [ROWS-1:0]      din,
  output logic [COLS*ROWS-1:0] dout
);

  // Column i lives at dout[i*ROWS +: ROWS]; column 0 is the leftmost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (shift) begin
      dout <= {din, dout[COLS*ROWS-1:ROWS]};
    end
  end

endmodule

// File: rtl/led_scroll_scan.sv
// Scrolling LED matrix driver: column window plus a column scan with registered outputs.
//   state    | meaning
//   ST_ON    | drive column sidx for SCAN_DIV clocks
//   ST_BLANK | drive nothing for BLANK_CYC clocks
module led_scroll_scan
  import matrix_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] col_in,
  input  logic            col_valid,
  input  logic            freeze,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_sel,
  output logic            frame_tick
);

  localparam int SW = $clog2(COLS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SIDX_LAST  = SW'(COLS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    BLANK_LAST = (BLANK_CYC > 0) ? 4'(BLANK_CYC - 1) : 4'd0;

  scan_state_t            state, state_n;
  logic [SW-1:0]          sidx, sidx_n;
  logic [DW-1:0]          dwell, dwell_n;
  logic [3:0]             bcnt, bcnt_n;
  logic [ROWS-1:0]        row_n;
  logic [COLS-1:0]        sel_n;
  logic                   tick_n;
  logic                   leave;
  logic [COLS*ROWS-1:0]   window;
  logic [ROWS-1:0]        cur_col;

  column_window #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (col_valid & ~freeze),
    .din   (col_in),
    .dout  (window)
  );

  // Sampled before the edge, so a shift on the same edge shows up one clock later.
  assign cur_col = window[sidx*ROWS +: ROWS];

  always_comb begin
    state_n = state;
    sidx_n  = sidx;
    dwell_n = dwell;
    bcnt_n  = bcnt;
    row_n   = '0;
    sel_n   = '0;
    tick_n  = 1'b0;
    leave   = 1'b0;
    case (state)
      ST_ON: begin
        row_n = cur_col;
        sel_n = COLS'(1) << sidx;
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          leave   = 1'b1;
          if (BLANK_CYC != 0) state_n = ST_BLANK;
        end else begin
          dwell_n = dwell + 1'b1;
        end
      end
      ST_BLANK: begin
        if (bcnt == BLANK_LAST) begin
          bcnt_n  = '0;
          state_n = ST_ON;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
    endcase
    if (leave) begin
      tick_n = (sidx == SIDX_LAST);
      sidx_n = tick_n ? '0 : sidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ON;
      sidx       <= '0;
      dwell      <= '0;
      bcnt       <= '0;
      row_out    <= '0;
      col_sel    <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      sidx       <= sidx_n;
      dwell      <= dwell_n;
      bcnt       <= bcnt_n;
      row_out    <= row_n;
      col_sel    <= sel_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_led_scroll_scan.sv
// Scoreboard bench for led_scroll_scan: expected column/row pairs are queued per frame,
// a monitor pops them at each column start and also checks scan cadence continuously.
module tb_led_scroll_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] col_in;
  logic       col_valid;
  logic       freeze;
  logic [6:0] row_out, row_out0;
  logic [7:0] col_sel, col_sel0;
  logic       frame_tick, frame_tick0;

  always #5 clk = ~clk;

  led_scroll_scan #(.COLS(8), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .col_valid  (col_valid),
    .freeze     (freeze),
    .row_out    (row_out),
    .col_sel    (col_sel),
    .frame_tick (frame_tick)
  );

  led_scroll_scan #(.COLS(8), .SCAN_DIV(4), .BLANK_CYC(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (7'd0),
    .col_valid  (1'b0),
    .freeze     (1'b0),
    .row_out    (row_out0),
    .col_sel    (col_sel0),
    .frame_tick (frame_tick0)
  );

  typedef struct packed {
    logic [7:0] cs;
    logic [6:0] row;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  task automatic push_frame(input logic [55:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.cs  = 8'(1 << i);
      e.row = w[i*7 +: 7];
      sbq.push_back(e);
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (frame_tick) return;
    end
    timeout("wait_tick");
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) return;
    end
    timeout("wait_empty");
  endtask

  task automatic wait_col(input logic [7:0] cs);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (col_sel == cs) return;
    end
    timeout("wait_col");
  endtask

  // Monitor for the blanked scanner.
  logic [7:0] prev_cs, last_nz;
  int         run, tcyc;
  bit         have_run, have_tick;
  exp_t       e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cs   = 8'h00;
      last_nz   = 8'h80;
      run       = 0;
      tcyc      = 0;
      have_run  = 1'b0;
      have_tick = 1'b0;
    end else begin
      tcyc++;
      if (col_sel == prev_cs) begin
        run++;
      end else begin
        if (have_run) begin
          if (prev_cs != 8'h00) check("dwell_len", run, 4);
          else                  check("blank_len", run, 1);
        end
        have_run = 1'b1;
        run      = 1;
        if (col_sel != 8'h00) begin
          check("col_order", col_sel, (last_nz == 8'h80) ? 8'h01 : (last_nz << 1));
          last_nz = col_sel;
          if (sbq.size() > 0) begin
            e_mon = sbq.pop_front();
            check("sb_col_sel", col_sel, e_mon.cs);
            check("sb_row_out", row_out, e_mon.row);
          end
        end
      end
      if (col_sel == 8'h00) check("blank_row", row_out, 0);
      if (frame_tick) begin
        check("tick_col", col_sel, 8'h80);
        if (have_tick) check("tick_period", tcyc, 40);
        have_tick = 1'b1;
        tcyc      = 0;
      end
      prev_cs = col_sel;
    end
  end

  // Monitor for the unblanked scanner.
  logic [7:0] prev0;
  int         run0, tcyc0;
  bit         have0, have_tick0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev0      = 8'h00;
      run0       = 0;
      tcyc0      = 0;
      have0      = 1'b0;
      have_tick0 = 1'b0;
    end else begin
      tcyc0++;
      if (col_sel0 == prev0) begin
        run0++;
      end else begin
        if (have0) begin
          check("nb_dwell_len", run0, 4);
          check("nb_order", col_sel0, (prev0 == 8'h80) ? 8'h01 : (prev0 << 1));
        end
        have0 = 1'b1;
        run0  = 1;
      end
      if (have0) check("nb_no_gap", (col_sel0 != 8'h00), 1);
      if (frame_tick0) begin
        if (have_tick0) check("nb_tick_period", tcyc0, 32);
        have_tick0 = 1'b1;
        tcyc0      = 0;
      end
      prev0 = col_sel0;
    end
  end

  logic [55:0] w;

  initial begin
    rst_n     = 1'b0;
    col_in    = 7'h00;
    col_valid = 1'b0;
    freeze    = 1'b0;
    #1;
    check("rst_col_sel", col_sel, 0);
    check("rst_row_out", row_out, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_col_sel0", col_sel0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Load 0x01..0x08 into the window.
    col_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      col_in = 7'(i);
      @(negedge clk);
    end
    col_valid = 1'b0;
    col_in    = 7'h00;
    for (int i = 0; i < 8; i++) w[i*7 +: 7] = 7'(i + 1);
    wait_tick();
    push_frame(w);
    wait_empty();

    // Scroll in 0x7F during column 0.
    wait_tick();
    @(negedge clk);
    @(negedge clk);
    check("scroll_start", col_sel, 8'h01);
    col_valid = 1'b1;
    col_in    = 7'h7F;
    @(negedge clk);
    col_valid = 1'b0;
    col_in    = 7'h00;
    check("scroll_pre", row_out, 7'h01);
    @(negedge clk);
    check("scroll_post", row_out, 7'h02);
    for (int i = 0; i < 7; i++) w[i*7 +: 7] = 7'(i + 2);
    w[49 +: 7] = 7'h7F;
    wait_tick();
    push_frame(w);
    wait_empty();

    // Frozen writes are discarded.
    freeze    = 1'b1;
    col_valid = 1'b1;
    col_in    = 7'h55;
    repeat (5) @(negedge clk);
    col_valid = 1'b0;
    freeze    = 1'b0;
    col_in    = 7'h00;
    wait_tick();
    push_frame(w);
    wait_empty();

    // Reset while column 5 is driven.
    wait_col(8'h20);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col_sel", col_sel, 0);
    check("mid_rst_row_out", row_out, 0);
    check("mid_rst_tick", frame_tick, 0);
    check("mid_rst_col_sel0", col_sel0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_col_sel", col_sel, 8'h01);
    check("post_rst_row_out", row_out, 0);
    check("post_rst_col_sel0", col_sel0, 8'h01);
    wait_tick();
    push_frame('0);
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scroll_scan.md
LED_SCROLL_SCAN -- requirements
Module: led_scroll_scan

Interface
REQ-001 Parameter COLS, default 8: number of matrix columns held in the display window; legal range 2..16.
REQ-002 Parameter SCAN_DIV, default 16: clocks each column is driven per scan; legal range 1..256.
REQ-003 Parameter BLANK_CYC, default 1: blanking clocks between columns; legal range 0..15.
REQ-004 clk  in  1  single clock for all state.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 col_in  in  7  glyph column pattern from the text-render stage; bit0 = top row.
REQ-007 col_valid  in  1  qualifies col_in for one clock.
REQ-008 freeze  in  1  when high, the window holds and scanning continues.
REQ-009 row_out  out  7  row drive for the selected column, active-high.
REQ-010 col_sel  out  COLS  one-hot column select, active-high; all-zero while blanking.
REQ-011 frame_tick  out  1  one-clock pulse when the scan wraps from the last column to column 0.

Function
REQ-012 The window SHALL hold COLS 7-bit columns, with index 0 leftmost.
REQ-013 On a clock edge with col_valid=1 and freeze=0, column[i] SHALL load column[i+1] for i<COLS-1, and column[COLS-1] SHALL load col_in (scroll left, enter right).
REQ-014 If col_valid=1 and freeze=1, col_in SHALL be discarded and the window SHALL be unchanged.
REQ-015 The scan FSM SHALL have two states: ON (drive a column) and BLANK (drive nothing); it also keeps scan index sidx (0..COLS-1), dwell counter (0..SCAN_DIV-1) and blank counter (0..BLANK_CYC-1).
REQ-016 In ON, dwell SHALL increment each clock; at dwell=SCAN_DIV-1 the FSM SHALL clear dwell and go to BLANK, or go directly to the next column when BLANK_CYC=0.
REQ-017 In BLANK, the blank counter SHALL increment each clock; at BLANK_CYC-1 the FSM SHALL clear the counter and go to ON.
REQ-018 On leaving a column, sidx SHALL advance by 1 and wrap from COLS-1 to 0; the wrap SHALL assert frame_tick for exactly that one clock.
REQ-019 All outputs SHALL be registered.
REQ-020 In ON, row_out SHALL be column[sidx] as held before the edge, and col_sel SHALL be 1<<sidx. A window shift SHALL therefore appear on row_out one clock after the col_valid edge.
REQ-021 In BLANK, row_out and col_sel SHALL be 0.
REQ-022 A shift and a column change on the same edge SHALL NOT interfere: the scan uses the pre-edge window and the shift completes normally.
REQ-023 The scan timing SHALL be independent of col_valid and freeze.
REQ-024 The frame period SHALL be COLS*(SCAN_DIV+BLANK_CYC) clocks.

Reset
REQ-025 While rst_n=0, regardless of clk: row_out=0, col_sel=0, frame_tick=0, all window columns=0, state=ON, sidx=0, dwell=0, blank counter=0.
REQ-026 The first rising clk edge after deassertion SHALL drive col_sel=1 (column 0). Reset asserted mid-scan or mid-shift SHALL abort without a partial update.

Structure
REQ-027 The shared package matrix_pkg SHALL hold the scan-state encoding (ON, BLANK), the row width constant ROWS=7, and the default values of COLS, SCAN_DIV and BLANK_CYC.
REQ-028 The window shift register SHALL be a sub-module column_window (parameters COLS and ROWS; ports clk, rst_n, shift, din, and flat dout).
REQ-029 The scan FSM and output registers SHALL live in led_scroll_scan.

Verification (COLS=8, SCAN_DIV=4, BLANK_CYC=1 unless stated)
REQ-030 Load: col_valid high for 8 clocks with col_in 0x01..0x08 -> column0=0x01 … column7=0x08; when col_sel=0x01, row_out=0x01; when col_sel=0x80, row_out=0x08.
REQ-031 Scroll: after REQ-030, a 9th column 0x7F -> column0=0x02, column7=0x7F; row_out reflects the new data one clock after the shift edge.
REQ-032 Timing: each column is driven for 4 clocks followed by 1 blank clock; frame_tick pulses once every 40 clocks; col_sel=0 in every blank clock.
REQ-033 Freeze: freeze=1 with col_valid=1 for 5 clocks of 0x55 -> window unchanged and the scan cadence unchanged.
REQ-034 No blank: BLANK_CYC=0 -> col_sel steps 0x01,0x02,…,0x80 every 4 clocks with no zero gaps; frame_tick every 32 clocks.
REQ-035 Reset mid-scan: rst_n low while sidx=5 -> outputs 0 immediately and window all zero; after release, col_sel=0x01 on the first edge.
